// File: rtl/pipe_pkg.sv
// Shared encodings for the writeback stage: FSM states, result-select codes
// and RV32 load funct3 values, plus small load-geometry helpers.
package pipe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_LO = 3'd1,
    ST_LOAD_HI = 3'd2,
    ST_WRITE   = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RSEL_ALU  = 2'd0,
    RSEL_LOAD = 2'd1,
    RSEL_CSR  = 2'd2,
    RSEL_NONE = 2'd3
  } rsel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic f3_valid(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Access size in bytes from the low funct3 bits (B/H/W).
  function automatic logic [2:0] load_span(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic crosses_word(input logic [1:0] offset, input logic [1:0] size);
    return ({1'b0, offset} + load_span(size)) > 3'd4;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the addressed bytes out of the
// {high,low} word pair and sign- or zero-extends them to XLEN.
module load_align
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] lo_word_i,
  input  logic [XLEN-1:0] hi_word_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [63:0] cat;
  logic [31:0] sel;

  assign cat = {hi_word_i[31:0], lo_word_i[31:0]};
  assign sel = cat[{1'b0, offset_i, 3'b000} +: 32];

  always_comb begin
    data_o = XLEN'(sel);
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){sel[7]}}, sel[7:0]};
      F3_LH:   data_o = {{(XLEN-16){sel[15]}}, sel[15:0]};
      F3_LBU:  data_o = XLEN'(sel[7:0]);
      F3_LHU:  data_o = XLEN'(sel[15:0]);
      default: data_o = XLEN'(sel);
    endcase
  end

endmodule

// File: rtl/pipe_writeback.sv
// Writeback stage: commits ALU/CSR results directly and performs (possibly
// split) loads with an acknowledge timeout before writing the register file.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready for an instruction
// ST_LOAD_LO | requesting the word holding the first load byte
// ST_LOAD_HI | requesting the following word for a word-crossing load
// ST_WRITE   | one-cycle register file write of the captured result
// ST_FAULT   | one-cycle loadFault pulse, no write
module pipe_writeback
  import pipe_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int TIMEOUT_CYCLES   = 255,
  parameter bit ALLOW_MISALIGNED = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stageValid,
  output logic                      stageReady,
  input  logic [1:0]                resultSelect,
  input  logic [2:0]                loadFunct3,
  input  logic [XLEN-1:0]           address,
  input  logic [XLEN-1:0]           aluResult,
  input  logic [XLEN-1:0]           csrData,
  input  logic [REG_ADDR_WIDTH-1:0] rdIndex,
  output logic                      memReq,
  output logic [XLEN-1:0]           memAddr,
  input  logic                      memAck,
  input  logic [XLEN-1:0]           memData,
  output logic                      registerWriteEnable,
  output logic [REG_ADDR_WIDTH-1:0] registerWriteAddress,
  output logic [XLEN-1:0]           registerWriteData,
  output logic                      loadFault
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [XLEN-1:0]           addr_q, addr_d;
  logic [XLEN-1:0]           data_q, data_d;
  logic [XLEN-1:0]           lo_q, lo_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [REG_ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [XLEN-1:0]           last_data_q, last_data_d;

  logic [XLEN-1:0] word_addr;
  logic [XLEN-1:0] align_lo;
  logic [XLEN-1:0] align_data;
  logic            in_cross;
  logic            q_cross;
  logic            we;

  assign word_addr = {addr_q[XLEN-1:2], 2'b00};
  assign in_cross  = crosses_word(address[1:0], loadFunct3[1:0]);
  assign q_cross   = crosses_word(addr_q[1:0], funct3_q[1:0]);

  // In LOAD_LO the low word is still on the bus; in LOAD_HI it was latched.
  assign align_lo = (state_q == ST_LOAD_LO) ? memData : lo_q;

  load_align #(.XLEN(XLEN)) u_load_align (
    .lo_word_i (align_lo),
    .hi_word_i (memData),
    .offset_i  (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .data_o    (align_data)
  );

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    data_d      = data_q;
    lo_d        = lo_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    stageReady  = 1'b0;
    memReq      = 1'b0;
    memAddr     = '0;
    loadFault   = 1'b0;
    we          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stageReady = 1'b1;
        if (stageValid) begin
          cnt_d = '0;
          case (rsel_e'(resultSelect))
            RSEL_ALU: begin
              data_d  = aluResult;
              rd_d    = rdIndex;
              state_d = ST_WRITE;
            end
            RSEL_CSR: begin
              data_d  = csrData;
              rd_d    = rdIndex;
              state_d = ST_WRITE;
            end
            RSEL_LOAD: begin
              funct3_d = loadFunct3;
              addr_d   = address;
              rd_d     = rdIndex;
              if (!f3_valid(loadFunct3) || (in_cross && !ALLOW_MISALIGNED))
                state_d = ST_FAULT;
              else
                state_d = ST_LOAD_LO;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end

      ST_LOAD_LO: begin
        memReq  = 1'b1;
        memAddr = word_addr;
        if (memAck) begin
          lo_d  = memData;
          cnt_d = '0;
          if (q_cross) begin
            state_d = ST_LOAD_HI;
          end else begin
            data_d  = align_data;
            state_d = ST_WRITE;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_LOAD_HI: begin
        memReq  = 1'b1;
        memAddr = word_addr + XLEN'(4);
        if (memAck) begin
          data_d  = align_data;
          state_d = ST_WRITE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WRITE: begin
        if (rd_q != '0) begin
          we          = 1'b1;
          last_addr_d = rd_q;
          last_data_d = data_q;
        end
        state_d = ST_IDLE;
      end

      ST_FAULT: begin
        loadFault = 1'b1;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Write port shows the live write, otherwise holds the last committed one.
  assign registerWriteEnable  = we;
  assign registerWriteAddress = we ? rd_q   : last_addr_q;
  assign registerWriteData    = we ? data_q : last_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      funct3_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      lo_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      lo_q        <= lo_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_writeback.sv
// Self-checking bench for pipe_writeback: directed cases plus random
// instructions checked against a byte-addressed memory reference model.
module tb_pipe_writeback;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stageValid;
  logic        stageReady;
  logic [1:0]  resultSelect;
  logic [2:0]  loadFunct3;
  logic [31:0] address;
  logic [31:0] aluResult;
  logic [31:0] csrData;
  logic [4:0]  rdIndex;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  logic        registerWriteEnable;
  logic [4:0]  registerWriteAddress;
  logic [31:0] registerWriteData;
  logic        loadFault;

  pipe_writeback #(
    .XLEN(32), .REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(TO), .ALLOW_MISALIGNED(1)
  ) dut (
    .clk(clk), .rst(rst), .stageValid(stageValid), .stageReady(stageReady),
    .resultSelect(resultSelect), .loadFunct3(loadFunct3), .address(address),
    .aluResult(aluResult), .csrData(csrData), .rdIndex(rdIndex),
    .memReq(memReq), .memAddr(memAddr), .memAck(memAck), .memData(memData),
    .registerWriteEnable(registerWriteEnable),
    .registerWriteAddress(registerWriteAddress),
    .registerWriteData(registerWriteData), .loadFault(loadFault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Byte-addressed memory reference; unwritten bytes read as zero.
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
  endfunction

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
  endtask

  function automatic int span_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] f3);
    int span;
    logic [31:0] v;
    span = span_of(f3);
    v = 32'h0;
    for (int i = 0; i < span; i++) v = v | (32'(byte_at(a + 32'(i))) << (8*i));
    if (!f3[2] && span < 4 && v[8*span-1]) v = v | (32'hFFFF_FFFF << (8*span));
    return v;
  endfunction

  // Memory responder: decides memAck for the coming edge on each falling edge.
  bit no_ack = 0, force_ack = 0, armed = 0;
  int fixed_wait = -1, wait_left = 0;

  always @(negedge clk) begin
    if (rst) begin
      memAck = 1'b0;
      armed  = 0;
    end else if (force_ack) begin
      memAck  = 1'b1;
      memData = $urandom;
    end else if (memReq !== 1'b1) begin
      memAck = 1'b0;
      armed  = 0;
    end else begin
      if (!armed) begin
        armed     = 1;
        wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
      end
      if (no_ack) memAck = 1'b0;
      else if (wait_left == 0) begin
        memAck  = 1'b1;
        memData = word_at(memAddr);
        armed   = 0;
      end else begin
        memAck = 1'b0;
        wait_left--;
      end
    end
  end

  int          r_wcnt, r_wcyc, r_fcnt, r_reqc, r_acks;
  logic [4:0]  r_waddr, r_hold_a;
  logic [31:0] r_wdata, r_hold_d;
  logic [4:0]  last_a;
  logic [31:0] last_d;

  // Issue one instruction and observe the stage until it is ready again.
  task automatic run_op(input logic [1:0] rs, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] alu, input logic [31:0] csr, input logic [4:0] rd);
    int guard, cyc;
    guard = 0;
    while (!stageReady && guard < 20) begin @(negedge clk); #2; guard++; end
    resultSelect = rs; loadFunct3 = f3; address = a;
    aluResult = alu; csrData = csr; rdIndex = rd; stageValid = 1'b1;
    @(negedge clk); #2;
    stageValid = 1'b0;
    r_wcnt = 0; r_wcyc = 0; r_fcnt = 0; r_reqc = 0; r_acks = 0;
    r_waddr = '0; r_wdata = '0;
    cyc = 1;
    while (1) begin
      if (registerWriteEnable) begin
        r_wcnt++; r_waddr = registerWriteAddress; r_wdata = registerWriteData; r_wcyc = cyc;
      end
      if (loadFault) r_fcnt++;
      if (memReq) r_reqc++;
      if (memReq && memAck) r_acks++;
      if (stageReady || cyc >= 60) break;
      @(negedge clk); #2;
      cyc++;
    end
    chk("op_done", {63'd0, stageReady}, 64'd1);
    r_hold_a = registerWriteAddress;
    r_hold_d = registerWriteData;
  endtask

  task automatic check_model(input logic [1:0] rs, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] alu, input logic [31:0] csr, input logic [4:0] rd);
    bit e_fault, e_write;
    int e_acc;
    logic [31:0] e_data;
    e_fault = (rs == 2'd1) && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    e_write = (rs != 2'd3) && !e_fault && (rd != 5'd0);
    e_data  = (rs == 2'd0) ? alu : (rs == 2'd2) ? csr : (e_fault ? 32'h0 : exp_load(a, f3));
    e_acc   = 0;
    if (rs == 2'd1 && !e_fault) e_acc = ((int'(a[1:0]) + span_of(f3)) > 4) ? 2 : 1;
    chk("write_count", 64'(r_wcnt), e_write ? 64'd1 : 64'd0);
    chk("fault_count", 64'(r_fcnt), e_fault ? 64'd1 : 64'd0);
    chk("mem_accesses", 64'(r_acks), 64'(e_acc));
    if (e_write) begin
      chk("write_addr", 64'(r_waddr), 64'(rd));
      chk("write_data", 64'(r_wdata), 64'(e_data));
      if (rs != 2'd1) chk("write_latency", 64'(r_wcyc), 64'd1);
      last_a = rd;
      last_d = e_data;
    end
    chk("hold_addr", 64'(r_hold_a), 64'(last_a));
    chk("hold_data", 64'(r_hold_d), 64'(last_d));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] a, alu, csr;
    logic [4:0]  rd;

    rst = 1'b1; stageValid = 1'b0; resultSelect = '0; loadFunct3 = '0;
    address = '0; aluResult = '0; csrData = '0; rdIndex = '0;
    memAck = 1'b0; memData = '0;
    last_a = '0; last_d = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_ready", {63'd0, stageReady}, 64'd1);
    chk("rst_memreq", {63'd0, memReq}, 64'd0);
    chk("rst_memaddr", 64'(memAddr), 64'd0);
    chk("rst_we", {63'd0, registerWriteEnable}, 64'd0);
    chk("rst_waddr", 64'(registerWriteAddress), 64'd0);
    chk("rst_wdata", 64'(registerWriteData), 64'd0);
    chk("rst_fault", {63'd0, loadFault}, 64'd0);
    rst = 1'b0;
    @(negedge clk); #2;

    // ALU write to r5
    run_op(2'd0, 3'b000, 32'h0, 32'h1234_5678, 32'h0, 5'd5);
    chk("alu_data", 64'(r_wdata), 64'h1234_5678);
    check_model(2'd0, 3'b000, 32'h0, 32'h1234_5678, 32'h0, 5'd5);

    // LB / LBU at 0x1003, ack after two wait cycles
    put_word(32'h1000, 32'h80FF_FFFF);
    fixed_wait = 2;
    run_op(2'd1, 3'b000, 32'h1003, 32'h0, 32'h0, 5'd6);
    chk("lb_data", 64'(r_wdata), 64'hFFFF_FF80);
    chk("lb_reqcycles", 64'(r_reqc), 64'd3);
    check_model(2'd1, 3'b000, 32'h1003, 32'h0, 32'h0, 5'd6);
    run_op(2'd1, 3'b100, 32'h1003, 32'h0, 32'h0, 5'd7);
    chk("lbu_data", 64'(r_wdata), 64'h0000_0080);
    check_model(2'd1, 3'b100, 32'h1003, 32'h0, 32'h0, 5'd7);

    // Word-crossing LW, zero-wait memory
    put_word(32'h2000, 32'hAABB_CCDD);
    put_word(32'h2004, 32'h1122_3344);
    fixed_wait = 0;
    run_op(2'd1, 3'b010, 32'h2002, 32'h0, 32'h0, 5'd8);
    chk("lw_split_data", 64'(r_wdata), 64'h3344_AABB);
    chk("lw_split_reqs", 64'(r_acks), 64'd2);
    check_model(2'd1, 3'b010, 32'h2002, 32'h0, 32'h0, 5'd8);

    // Crossing LH at top of address space wraps to 0x0
    put_word(32'hFFFF_FFFC, 32'h5A00_0000);
    put_word(32'h0000_0000, 32'h0000_00C3);
    run_op(2'd1, 3'b001, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd9);
    chk("lh_wrap_data", 64'(r_wdata), 64'hFFFF_C35A);
    check_model(2'd1, 3'b001, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd9);
    fixed_wait = -1;

    // Timeout: no acknowledge at all
    no_ack = 1;
    run_op(2'd1, 3'b010, 32'h3000, 32'h0, 32'h0, 5'd7);
    chk("to_reqcycles", 64'(r_reqc), 64'(TO));
    chk("to_fault", 64'(r_fcnt), 64'd1);
    chk("to_write", 64'(r_wcnt), 64'd0);
    chk("to_hold_data", 64'(r_hold_d), 64'(last_d));
    no_ack = 0;

    // rd=0, CSR, no-write and invalid funct3
    run_op(2'd0, 3'b000, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd0);
    check_model(2'd0, 3'b000, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd0);
    run_op(2'd2, 3'b000, 32'h0, 32'h0, 32'hCAFE_0001, 5'd31);
    check_model(2'd2, 3'b000, 32'h0, 32'h0, 32'hCAFE_0001, 5'd31);
    run_op(2'd3, 3'b000, 32'h0, 32'h1111_1111, 32'h0, 5'd3);
    check_model(2'd3, 3'b000, 32'h0, 32'h1111_1111, 32'h0, 5'd3);
    run_op(2'd1, 3'b011, 32'h1000, 32'h0, 32'h0, 5'd4);
    chk("badf3_reqs", 64'(r_reqc), 64'd0);
    check_model(2'd1, 3'b011, 32'h1000, 32'h0, 32'h0, 5'd4);

    // Random mix
    for (int i = 0; i < 60; i++) begin
      rs  = 2'($urandom_range(0, 3));
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      if (i % 7 == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      alu = $urandom;
      csr = $urandom;
      rd  = 5'($urandom_range(0, 31));
      if (rs == 2'd1) begin
        put_word({a[31:2], 2'b00}, $urandom);
        put_word({a[31:2], 2'b00} + 32'd4, $urandom);
      end
      run_op(rs, f3, a, alu, csr, rd);
      check_model(rs, f3, a, alu, csr, rd);
    end

    // Reset in the middle of LOAD_LO; a late ack must be ignored
    no_ack = 1;
    resultSelect = 2'd1; loadFunct3 = 3'b010; address = 32'h4000; rdIndex = 5'd12;
    stageValid = 1'b1;
    @(negedge clk); #2;
    stageValid = 1'b0;
    chk("mid_memreq", {63'd0, memReq}, 64'd1);
    @(negedge clk); #2;
    rst = 1'b1;
    @(negedge clk); #2;
    chk("mrst_memreq", {63'd0, memReq}, 64'd0);
    chk("mrst_ready", {63'd0, stageReady}, 64'd1);
    chk("mrst_fault", {63'd0, loadFault}, 64'd0);
    chk("mrst_wdata", 64'(registerWriteData), 64'd0);
    chk("mrst_waddr", 64'(registerWriteAddress), 64'd0);
    rst = 1'b0;
    no_ack = 0;
    force_ack = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      chk("late_ack_we", {63'd0, registerWriteEnable}, 64'd0);
      chk("late_ack_fault", {63'd0, loadFault}, 64'd0);
      chk("late_ack_ready", {63'd0, stageReady}, 64'd1);
    end
    force_ack = 0;
    last_a = '0;
    last_d = '0;
    run_op(2'd0, 3'b000, 32'h0, 32'h0BAD_F00D, 32'h0, 5'd2);
    check_model(2'd0, 3'b000, 32'h0, 32'h0BAD_F00D, 32'h0, 5'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
